// File: rtl/gcd_pkg.sv
// Shared types and helpers for the gcd feeder stage.
package gcd_pkg;

  // Default operand/result width of the gcd core.
  localparam int GCD_WIDTH = 32;

  // Widest operand the bypass helper can inspect.
  localparam int MAX_OP_W = 64;

  // Job sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  // A job bypasses the core when either operand is zero: gcd(x,0)=x, gcd(0,0)=0.
  function automatic logic is_bypass(input logic [MAX_OP_W-1:0] a,
                                     input logic [MAX_OP_W-1:0] b);
    is_bypass = (a == {MAX_OP_W{1'b0}}) || (b == {MAX_OP_W{1'b0}});
  endfunction

endpackage

// File: rtl/gcd_op_fifo.sv
// Flop-based operand FIFO with count-based full/empty flags.
module gcd_op_fifo
  import gcd_pkg::*;
#(
  parameter int W     = 2 * GCD_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == {CW{1'b0}});
  assign dout  = mem_q[rd_ptr_q];

  // Qualify requests against the flags and compute next pointers and count.
  always_comb begin
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

endmodule

// File: rtl/gcd_feeder.sv
// Feeds queued operand pairs to the gcd core one job at a time and
// presents each result on a one-entry valid/ready output register.
module gcd_feeder
  import gcd_pkg::*;
#(
  parameter int WIDTH      = GCD_WIDTH,
  parameter int DEPTH      = 4,
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_opa,
  input  logic [WIDTH-1:0] in_opb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] out_cycles,
  output logic             out_err,
  output logic [WIDTH-1:0] core_opa,
  output logic [WIDTH-1:0] core_opb,
  output logic             core_start,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             busy
);

  // Watchdog counter only needs to reach MAX_CYCLES-1 before it fires.
  localparam int          WD_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [63:0] CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
  localparam logic [63:0] WD_LIMIT  = 64'(MAX_CYCLES);

  // Clamp a wide cycle count into the out_cycles field.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [63:0] v);
    if (v > CNT_MAX) begin
      sat_cnt = {CNT_W{1'b1}};
    end else begin
      sat_cnt = v[CNT_W-1:0];
    end
  endfunction

  state_e             state_q, state_d;
  logic [WD_W-1:0]    cnt_q, cnt_d;
  logic               core_start_q, core_start_d;
  logic [WIDTH-1:0]   core_opa_q, core_opa_d;
  logic [WIDTH-1:0]   core_opb_q, core_opb_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [CNT_W-1:0]   out_cycles_q, out_cycles_d;
  logic               out_err_q, out_err_d;

  logic [2*WIDTH-1:0] fifo_dout_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_pop_s;
  logic [WIDTH-1:0]   head_a_s;
  logic [WIDTH-1:0]   head_b_s;
  logic               out_free_s;
  logic [63:0]        cyc_wide_s;
  logic [WD_W-1:0]    cnt_inc_s;

  gcd_op_fifo #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid & ~fifo_full_s),
    .pop   (fifo_pop_s),
    .din   ({in_opa, in_opb}),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_a_s   = fifo_dout_s[2*WIDTH-1:WIDTH];
  assign head_b_s   = fifo_dout_s[WIDTH-1:0];
  assign out_free_s = ~out_valid_q | out_ready;
  assign cyc_wide_s = 64'(cnt_q) + 64'd1;
  assign cnt_inc_s  = (cnt_q == {WD_W{1'b1}}) ? cnt_q : cnt_q + WD_W'(1);

  assign in_ready   = ~fifo_full_s;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_cycles = out_cycles_q;
  assign out_err    = out_err_q;
  assign core_opa   = core_opa_q;
  assign core_opb   = core_opb_q;
  assign core_start = core_start_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty_s;

  // Job sequencing: launch or bypass from IDLE, wait for done or watchdog in RUN, one low cycle in GAP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_start_d = core_start_q;
    core_opa_d   = core_opa_q;
    core_opb_d   = core_opb_q;
    out_valid_d  = out_valid_q & ~out_ready;
    out_result_d = out_result_q;
    out_cycles_d = out_cycles_q;
    out_err_d    = out_err_q;
    fifo_pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (~fifo_empty_s && out_free_s) begin
          fifo_pop_s = 1'b1;
          if (is_bypass(64'(head_a_s), 64'(head_b_s))) begin
            out_valid_d  = 1'b1;
            out_result_d = head_a_s | head_b_s;
            out_cycles_d = {CNT_W{1'b0}};
            out_err_d    = 1'b0;
            state_d      = IDLE;
          end else begin
            core_opa_d   = head_a_s;
            core_opb_d   = head_b_s;
            core_start_d = 1'b1;
            cnt_d        = {WD_W{1'b0}};
            state_d      = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_inc_s;
        if (core_done) begin
          out_valid_d  = 1'b1;
          out_result_d = core_result;
          out_cycles_d = sat_cnt(cyc_wide_s);
          out_err_d    = 1'b0;
          core_start_d = 1'b0;
          state_d      = GAP;
        end else if (cyc_wide_s == WD_LIMIT) begin
          out_valid_d  = 1'b1;
          out_result_d = {WIDTH{1'b0}};
          out_cycles_d = sat_cnt(WD_LIMIT);
          out_err_d    = 1'b1;
          core_start_d = 1'b0;
          state_d      = GAP;
        end else begin
          state_d = RUN;
        end
      end
      GAP: begin
        core_start_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        core_start_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State, core interface and output register; reset drops any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= {WD_W{1'b0}};
      core_start_q <= 1'b0;
      core_opa_q   <= {WIDTH{1'b0}};
      core_opb_q   <= {WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= {WIDTH{1'b0}};
      out_cycles_q <= {CNT_W{1'b0}};
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_start_q <= core_start_d;
      core_opa_q   <= core_opa_d;
      core_opb_q   <= core_opb_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_cycles_q <= out_cycles_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Scoreboard bench for gcd_feeder with a behavioural gcd core that can be told to hang.
module tb_gcd_feeder;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int MAXC  = 16;
  localparam int CNT_W = 16;
  localparam int LAT   = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_opa;
  logic [WIDTH-1:0]  in_opb;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [CNT_W-1:0]  out_cycles;
  logic              out_err;
  logic [WIDTH-1:0]  core_opa;
  logic [WIDTH-1:0]  core_opb;
  logic              core_start;
  logic              core_done;
  logic [WIDTH-1:0]  core_result;
  logic              busy;

  always #5 clk = ~clk;

  gcd_feeder #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAXC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opa      (in_opa),
    .in_opb      (in_opb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_cycles  (out_cycles),
    .out_err     (out_err),
    .core_opa    (core_opa),
    .core_opb    (core_opb),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cyc;
    logic             err;
    bit               cyc_nz;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural gcd core ----------------
  function automatic logic [WIDTH-1:0] gcd_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, r;
    x = a;
    y = b;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  bit               hang = 1'b0;
  bit               cb_busy;
  int               cb_t;
  logic [WIDTH-1:0] cb_a, cb_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cb_busy     <= 1'b0;
      cb_t        <= 0;
      cb_a        <= '0;
      cb_b        <= '0;
      core_done   <= 1'b0;
      core_result <= '0;
    end else if (!cb_busy) begin
      if (core_start) begin
        cb_busy <= 1'b1;
        cb_t    <= 0;
        cb_a    <= core_opa;
        cb_b    <= core_opb;
      end
    end else if (!core_start) begin
      cb_busy   <= 1'b0;
      core_done <= 1'b0;
    end else if (!core_done && !hang) begin
      if (cb_t == LAT) begin
        core_done   <= 1'b1;
        core_result <= gcd_f(cb_a, cb_b);
      end else begin
        cb_t <= cb_t + 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got result %0d, required no output", out_result);
      end else begin
        e = exp_q.pop_front();
        check("out_result", 64'(out_result), 64'(e.res));
        check("out_err", 64'(out_err), 64'(e.err));
        if (e.cyc_nz) check("out_cycles_nonzero", 64'(out_cycles != '0), 64'd1);
        else          check("out_cycles", 64'(out_cycles), 64'(e.cyc));
      end
    end
  end

  // ---------------- core_start protocol checker ----------------
  logic             prev_start = 1'b0;
  logic [WIDTH-1:0] prev_a = '0, prev_b = '0;
  int               low_len = 0;
  int               rises = 0;
  int               strict_rises = 0;
  bit               strict = 1'b0;

  always @(negedge clk) begin
    if (core_start && prev_start) begin
      check("core_opa_stable", 64'(core_opa), 64'(prev_a));
      check("core_opb_stable", 64'(core_opb), 64'(prev_b));
    end
    if (core_start && !prev_start) begin
      rises <= rises + 1;
      check("start_gap_min", 64'(low_len >= 1), 64'd1);
      if (strict) begin
        strict_rises <= strict_rises + 1;
        // Back-to-back jobs: one GAP cycle followed by the IDLE launch cycle.
        if (strict_rises > 0) check("start_gap_len", 64'(low_len), 64'd2);
      end
    end
    low_len    <= core_start ? 0 : low_len + 1;
    prev_start <= core_start;
    prev_a     <= core_opa;
    prev_b     <= core_opb;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    bit rdy;
    guard    = 0;
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) check("push_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_core(input logic [WIDTH-1:0] r);
    exp_t e;
    e.res = r; e.cyc = '0; e.err = 1'b0; e.cyc_nz = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic exp_fixed(input logic [WIDTH-1:0] r, input logic [CNT_W-1:0] c, input logic er);
    exp_t e;
    e.res = r; e.cyc = c; e.err = er; e.cyc_nz = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int r0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opa    = '0;
    in_opb    = '0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_cycles", 64'(out_cycles), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_core_opa", 64'(core_opa), 64'd0);
    check("rst_core_opb", 64'(core_opb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // 1: core jobs
    out_ready = 1'b1;
    exp_core(32'd6); send(32'd102, 32'd12);
    exp_core(32'd1); send(32'd82066, 32'd36915);
    exp_core(32'd9); send(32'd68490, 32'd78579);
    idle(1);
    drain();

    // 2: zero-operand bypass
    r0 = rises;
    exp_fixed(32'd45, 16'd0, 1'b0); send(32'd0, 32'd45);
    exp_fixed(32'd45, 16'd0, 1'b0); send(32'd45, 32'd0);
    exp_fixed(32'd0,  16'd0, 1'b0); send(32'd0, 32'd0);
    idle(1);
    drain();
    check("bypass_no_core_start", 64'(rises), 64'(r0));

    // 3: back-pressure, FIFO full after DEPTH+1 accepts
    out_ready = 1'b0;
    exp_core(32'd6);  send(32'd102, 32'd12);
    exp_core(32'd6);  send(32'd12, 32'd18);
    exp_core(32'd7);  send(32'd35, 32'd49);
    exp_core(32'd25); send(32'd100, 32'd75);
    exp_core(32'd7);  send(32'd21, 32'd14);
    in_valid = 1'b1;
    in_opa   = 32'd60;
    in_opb   = 32'd48;
    repeat (8) @(posedge clk);
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_busy", 64'(busy), 64'd1);
    strict    = 1'b1;
    out_ready = 1'b1;
    exp_core(32'd12); send(32'd60, 32'd48);
    idle(1);
    drain();
    strict = 1'b0;
    check("queued_jobs_launched", 64'(strict_rises), 64'd5);

    // 4: watchdog abort, then a normal job
    hang = 1'b1;
    exp_fixed(32'd0, 16'd16, 1'b1); send(32'd12, 32'd18);
    idle(1);
    drain();
    hang = 1'b0;
    exp_core(32'd6); send(32'd48, 32'd18);
    idle(1);
    drain();

    // 5: asynchronous reset during RUN with jobs queued
    hang = 1'b1;
    send(32'd30, 32'd12);
    send(32'd5, 32'd10);
    send(32'd7, 32'd21);
    idle(0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_core_start", 64'(core_start), 64'd1);
    reset = 1'b1;
    #1;
    check("areset_core_start", 64'(core_start), 64'd0);
    check("areset_out_valid", 64'(out_valid), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    check("areset_in_ready", 64'(in_ready), 64'd1);
    check("areset_core_opa", 64'(core_opa), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hang  = 1'b0;
    idle(2);
    exp_core(32'd8); send(32'd34456, 32'd36928);
    idle(1);
    drain();

    check("final_busy", 64'(busy), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
